// File: rtl/special_color_pipe.sv
// Colour special-effects unit: alpha blend, brighten and darken on a 3-stage
// valid/ready pipeline, with shadowed configuration loaded on a strobe.
module special_color_pipe #(
    parameter int CH_W   = 5,
    parameter int NUM_CH = 3,
    parameter int COEF_W = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cfg_load,
    input  logic [1:0]               cfg_mode,
    input  logic [5:0]               cfg_target1,
    input  logic [5:0]               cfg_target2,
    input  logic [COEF_W-1:0]        cfg_eva,
    input  logic [COEF_W-1:0]        cfg_evb,
    input  logic [COEF_W-1:0]        cfg_evy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*CH_W-1:0]   in_top,
    input  logic [NUM_CH*CH_W-1:0]   in_bot,
    input  logic [2:0]               in_top_id,
    input  logic [2:0]               in_bot_id,
    input  logic                     in_top_semi,
    input  logic                     in_win_fx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*CH_W-1:0]   out_color,
    output logic [15:0]              fx_count
);
    localparam int PIX_W  = NUM_CH * CH_W;
    localparam int PROD_W = CH_W + COEF_W;
    localparam logic [CH_W-1:0] MAX = '1;

    typedef enum logic [1:0] {
        MODE_NONE   = 2'b00,
        MODE_ALPHA  = 2'b01,
        MODE_BRIGHT = 2'b10,
        MODE_DARK   = 2'b11
    } mode_t;

    function automatic logic [COEF_W-1:0] clamp_coef(input logic [COEF_W-1:0] c);
        return (c > COEF_W'(16)) ? COEF_W'(16) : c;
    endfunction

    // Ids 6 and 7 index the zero padding, so they never hit a target.
    function automatic logic target_hit(input logic [5:0] mask, input logic [2:0] id);
        logic [7:0] m;
        m = {2'b00, mask};
        return m[id];
    endfunction

    function automatic logic [CH_W-1:0] finish_ch(input mode_t mode, input logic [CH_W-1:0] a,
                                                  input logic [PROD_W-1:0] pa,
                                                  input logic [PROD_W-1:0] pb);
        logic [PROD_W:0] scaled;
        scaled = ({1'b0, pa} + {1'b0, pb}) >> 4;
        case (mode)
            MODE_ALPHA:  return (scaled > (PROD_W+1)'(MAX)) ? MAX : CH_W'(scaled);
            MODE_BRIGHT: return CH_W'(PROD_W'(a) + (pa >> 4));
            MODE_DARK:   return CH_W'(PROD_W'(a) - (pa >> 4));
            default:     return a;
        endcase
    endfunction

    mode_t               sh_mode;
    logic [5:0]          sh_t1, sh_t2;
    logic [COEF_W-1:0]   sh_eva, sh_evb, sh_evy;

    logic                vld_p1, vld_p2;
    mode_t               mode_p1, mode_p2;
    logic [PIX_W-1:0]    top_p1, bot_p1, a_p2;
    logic [COEF_W-1:0]   eva_p1, evb_p1, evy_p1;
    logic [NUM_CH-1:0][PROD_W-1:0] pa_d, pb_d, pa_p2, pb_p2;
    logic [PIX_W-1:0]    color_p3;
    logic                fx_p3;

    logic                t1, t2;
    mode_t               eff_mode;
    logic                ready_out, ready_p2, accept, adv_p1, adv_p2;

    assign ready_out = ~out_valid | out_ready;
    assign ready_p2  = ~vld_p2 | ready_out;
    assign adv_p1    = vld_p1 & ready_p2;
    assign adv_p2    = vld_p2 & ready_out;
    assign in_ready  = ~reset & (~vld_p1 | adv_p1);
    assign accept    = in_valid & in_ready;

    // Stage 1: decide the effective mode against the current shadow config
    always_comb begin
        t1       = target_hit(sh_t1, in_top_id);
        t2       = target_hit(sh_t2, in_bot_id);
        eff_mode = MODE_NONE;
        if (in_top_semi && t2)
            eff_mode = MODE_ALPHA;
        else if (in_win_fx && t1 && (sh_mode != MODE_ALPHA || t2))
            eff_mode = sh_mode;
    end

    // Stage 2: per-channel coefficient products
    always_comb begin
        pa_d = '0;
        pb_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            case (mode_p1)
                MODE_ALPHA: begin
                    pa_d[c] = PROD_W'(top_p1[c*CH_W +: CH_W]) * PROD_W'(eva_p1);
                    pb_d[c] = PROD_W'(bot_p1[c*CH_W +: CH_W]) * PROD_W'(evb_p1);
                end
                MODE_BRIGHT: pa_d[c] = PROD_W'(MAX - top_p1[c*CH_W +: CH_W]) * PROD_W'(evy_p1);
                MODE_DARK:   pa_d[c] = PROD_W'(top_p1[c*CH_W +: CH_W]) * PROD_W'(evy_p1);
                default: ;
            endcase
        end
    end

    // Stage 3: combine, saturate and apply
    always_comb begin
        color_p3 = '0;
        for (int c = 0; c < NUM_CH; c++)
            color_p3[c*CH_W +: CH_W] = finish_ch(mode_p2, a_p2[c*CH_W +: CH_W], pa_p2[c], pb_p2[c]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sh_mode   <= MODE_NONE;
            sh_t1     <= '0;
            sh_t2     <= '0;
            sh_eva    <= '0;
            sh_evb    <= '0;
            sh_evy    <= '0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
            out_color <= '0;
            fx_count  <= '0;
        end else begin
            if (cfg_load) begin
                sh_mode <= mode_t'(cfg_mode);
                sh_t1   <= cfg_target1;
                sh_t2   <= cfg_target2;
                sh_eva  <= clamp_coef(cfg_eva);
                sh_evb  <= clamp_coef(cfg_evb);
                sh_evy  <= clamp_coef(cfg_evy);
            end
            if (in_ready)  vld_p1    <= in_valid;
            if (ready_p2)  vld_p2    <= vld_p1;
            if (ready_out) out_valid <= vld_p2;
            if (adv_p2)    out_color <= color_p3;
            if (out_valid && out_ready && fx_p3 && fx_count != 16'hFFFF)
                fx_count <= fx_count + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            top_p1  <= in_top;
            bot_p1  <= in_bot;
            mode_p1 <= eff_mode;
            eva_p1  <= sh_eva;
            evb_p1  <= sh_evb;
            evy_p1  <= sh_evy;
        end
        if (adv_p1) begin
            mode_p2 <= mode_p1;
            a_p2    <= top_p1;
            pa_p2   <= pa_d;
            pb_p2   <= pb_d;
        end
        if (adv_p2)
            fx_p3 <= (mode_p2 != MODE_NONE);
    end

endmodule
